// File: rtl/pc_stack_n2t.sv
// pc_stack_n2t: 16-bit program counter with a hardware return-address stack.
// Drives the instruction-memory address of the CPU datapath.
//
// Operations are taken one per rising edge, highest priority first:
// clear, call, ret, load, inc, hold. Only the winning operation acts.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   in        in   jump/call target address
//   load      in   out <= in
//   inc       in   out <= out + 1 (wraps, no flag)
//   clear     in   synchronous clear of PC, stack depth and error flags
//   call      in   push out+1, then out <= in
//   ret       in   pop stack top into out
//   out       out  current program counter (registered)
//   full      out  stack holds DEPTH entries
//   empty     out  stack holds no entries
//   overflow  out  sticky: call attempted while full
//   underflow out  sticky: ret attempted while empty
module pc_stack_n2t #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             clear,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_pc_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic             w_push;
  logic [WIDTH-1:0] w_pc_plus1;
  logic [AW-1:0]    w_push_idx;
  logic [AW-1:0]    w_top_idx;
  logic             w_full;
  logic             w_empty;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == {CW{1'b0}});
  assign w_pc_plus1 = r_pc + WIDTH'(1);
  // Pushes only happen below DEPTH, so the low bits address the free slot.
  assign w_push_idx = r_count[AW-1:0];
  // When full the low bits are 0, so minus one lands on DEPTH-1 as needed.
  assign w_top_idx  = r_count[AW-1:0] - AW'(1);

  // Next-state selection in strict priority order; error flags only set
  // when the winning operation itself is illegal.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    if (clear) begin
      w_pc_nxt    = {WIDTH{1'b0}};
      w_count_nxt = {CW{1'b0}};
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
    end else if (call) begin
      if (!w_full) begin
        w_push      = 1'b1;
        w_count_nxt = r_count + CW'(1);
        w_pc_nxt    = in;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else if (ret) begin
      if (!w_empty) begin
        w_pc_nxt    = r_stack[w_top_idx];
        w_count_nxt = r_count - CW'(1);
      end else begin
        w_unf_nxt = 1'b1;
      end
    end else if (load) begin
      w_pc_nxt = in;
    end else if (inc) begin
      w_pc_nxt = w_pc_plus1;
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // PC, depth counter and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= {WIDTH{1'b0}};
      r_count <= {CW{1'b0}};
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Return-address storage; cleared on reset so no X ever reaches out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stack[i] <= {WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_stack[w_push_idx] <= w_pc_plus1;
    end else begin
      r_stack <= r_stack;
    end
  end

  assign out       = r_pc;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_pc_stack_n2t.sv
// Scoreboard bench for pc_stack_n2t: the driver applies one command per
// cycle, runs a queue-based stack model and pushes the expected outputs;
// a monitor pops one expectation after every rising edge and compares.
module tb_pc_stack_n2t;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             load, inc, clear, call, ret;
  logic [WIDTH-1:0] out;
  logic             full, empty, overflow, underflow;

  pc_stack_n2t #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc),
    .clear(clear), .call(call), .ret(ret), .out(out), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Behavioural model: PC value, a LIFO queue and two sticky flags.
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stk[$];
  logic             m_ovf, m_unf;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.pc    = m_pc;
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One command: drive at negedge, advance model, queue the expectation.
  task automatic cmd(input logic cl, input logic ca, input logic rt,
                     input logic ld, input logic ic,
                     input logic [WIDTH-1:0] din, input string tag);
    @(negedge clk);
    clear = cl; call = ca; ret = rt; load = ld; inc = ic; in = din;
    if (cl) begin
      model_reset();
    end else if (ca) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc = din;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (ld) begin
      m_pc = din;
    end else if (ic) begin
      m_pc = m_pc + 16'd1;
    end
    exp_q.push_back(model_now());
    tag_q.push_back(tag);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    clear = 1'b0; call = 1'b0; ret = 1'b0; load = 1'b0; inc = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic check_direct(input string tag);
    check({tag, "_out"}, 32'(out), 32'(m_pc));
    check({tag, "_flags"}, {28'd0, full, empty, overflow, underflow},
          {28'd0, m_stk.size() == DEPTH, m_stk.size() == 0, m_ovf, m_unf});
  endtask

  // Monitor: one expectation per rising edge once something is queued.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_out"}, 32'(out), 32'(e.pc));
        check({t, "_flags"}, {28'd0, full, empty, overflow, underflow},
              {28'd0, e.full, e.empty, e.ovf, e.unf});
      end
    end
  end

  initial begin
    reset = 1'b0;
    in = '0; load = 1'b0; inc = 1'b0; clear = 1'b0; call = 1'b0; ret = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_direct("reset");
    @(negedge clk);
    reset = 1'b1;

    // Increment and wrap
    repeat (3) cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "inc");
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, "load_ffff");
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "inc_wrap");

    // Call / return
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, "load_10");
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, "call_200");
    repeat (5) cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "inc_sub");
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "ret_11");

    // Nesting to full, overflow, then unwind
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "clear");
    for (int k = 0; k < DEPTH; k++)
      cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000 + 16'(k), "nest_call");
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, "call_overflow");
    for (int k = 0; k < DEPTH; k++)
      cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "unwind_ret");

    // Underflow stickiness
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0042, "load_42");
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "ret_underflow");
    repeat (2) cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "inc_sticky");
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "clear_flags");

    // Priority
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, "load_5");
    cmd(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0300, "all_ops");
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "ret_6");
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, "call_400");
    cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0500, "clear_call");
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "ret_after_clr");
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "clear_ret");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic cl, ca, rt, ld, ic;
      cl = ($urandom_range(0, 99) < 3);
      ca = ($urandom_range(0, 99) < 30);
      rt = ($urandom_range(0, 99) < 30);
      ld = ($urandom_range(0, 99) < 15);
      ic = ($urandom_range(0, 99) < 50);
      cmd(cl, ca, rt, ld, ic, 16'($urandom), "rand");
    end

    // Async reset mid-operation
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "pre_clear");
    for (int k = 0; k < 3; k++)
      cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0700 + 16'(k), "pre_call");
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "pre_ret_under_guard");
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, "pre_call2");
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0123, "pre_load");
    idle_inputs();
    drain();
    check("pre_reset_count3", 32'(m_stk.size()), 32'd3);
    check("pre_reset_out", 32'(out), 32'h0123);
    @(negedge clk);
    #1;
    reset = 1'b0;
    inc = 1'b1;
    #1;
    model_reset();
    check_direct("async_reset");
    @(posedge clk);
    #1;
    check_direct("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    inc = 1'b0;
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "post_reset_inc");
    idle_inputs();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
